// File: rtl/comb_gates_pkg.sv
// Shared definitions for the comb_gates family: gate-function encoding on the
// 2-bit mode input.
package comb_gates_pkg;

  typedef enum logic [1:0] {
    MODE_OAI22 = 2'd0,
    MODE_AOI22 = 2'd1,
    MODE_OA22  = 2'd2,
    MODE_AO22  = 2'd3
  } gate_mode_e;

endpackage

// File: rtl/comb_gates_lane22.sv
// Single-bit 2-2 gate lane: OR/AND pairs combined, optionally inverted, per mode.
module comb_gates_lane22
  import comb_gates_pkg::*;
(
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic [1:0] mode,
  output logic       out
);

  always_comb begin
    out = 1'b0;
    case (gate_mode_e'(mode))
      MODE_OAI22: out = ~((in0 | in1) & (in2 | in3));
      MODE_AOI22: out = ~((in0 & in1) | (in2 & in3));
      MODE_OA22:  out =   (in0 | in1) & (in2 | in3);
      MODE_AO22:  out =   (in0 & in1) | (in2 & in3);
      default:    out = 1'b0;
    endcase
  end

endmodule

// File: rtl/comb_gates_oai_pipe.sv
// Two-stage valid/ready pipeline around NBITS comb_gates_lane22 lanes with a
// saturating transfer counter. Define COMB_GATES_OAI_PIPE_POPCOUNT_EN to add out_ones.
module comb_gates_oai_pipe
  import comb_gates_pkg::*;
#(
  parameter int unsigned NBITS    = 8,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NBITS-1:0]    in0,
  input  logic [NBITS-1:0]    in1,
  input  logic [NBITS-1:0]    in2,
  input  logic [NBITS-1:0]    in3,
  input  logic [1:0]          mode,
  input  logic                in_val,
  output logic                in_rdy,
  output logic [NBITS-1:0]    out,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [CNT_BITS-1:0] out_count
`ifdef COMB_GATES_OAI_PIPE_POPCOUNT_EN
  ,
  output logic [$clog2(NBITS+1)-1:0] out_ones
`endif
);

  logic                s1_val_q, s1_val_d;
  logic [NBITS-1:0]    s1_in0_q, s1_in0_d;
  logic [NBITS-1:0]    s1_in1_q, s1_in1_d;
  logic [NBITS-1:0]    s1_in2_q, s1_in2_d;
  logic [NBITS-1:0]    s1_in3_q, s1_in3_d;
  logic [1:0]          s1_mode_q, s1_mode_d;
  logic                s2_val_q, s2_val_d;
  logic [NBITS-1:0]    out_q, out_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic                s2_rdy;
  logic                accept;
  logic                advance;
  logic                fire;
  logic [NBITS-1:0]    lane_out;

  for (genvar i = 0; i < NBITS; i++) begin : g_lane
    comb_gates_lane22 u_lane (
      .in0  (s1_in0_q[i]),
      .in1  (s1_in1_q[i]),
      .in2  (s1_in2_q[i]),
      .in3  (s1_in3_q[i]),
      .mode (s1_mode_q),
      .out  (lane_out[i])
    );
  end

  always_comb begin
    s2_rdy  = ~s2_val_q | out_rdy;
    in_rdy  = ~s1_val_q | s2_rdy;
    accept  = in_val & in_rdy & ~reset;
    advance = s1_val_q & s2_rdy;
    fire    = s2_val_q & out_rdy;

    s1_val_d  = s1_val_q;
    s1_in0_d  = s1_in0_q;
    s1_in1_d  = s1_in1_q;
    s1_in2_d  = s1_in2_q;
    s1_in3_d  = s1_in3_q;
    s1_mode_d = s1_mode_q;
    s2_val_d  = s2_val_q;
    out_d     = out_q;
    cnt_d     = cnt_q;

    if (accept) begin
      s1_val_d  = 1'b1;
      s1_in0_d  = in0;
      s1_in1_d  = in1;
      s1_in2_d  = in2;
      s1_in3_d  = in3;
      s1_mode_d = mode;
    end else if (advance) begin
      s1_val_d = 1'b0;
    end

    // The result register only loads from a valid S1, so out holds otherwise.
    if (advance) begin
      s2_val_d = 1'b1;
      out_d    = lane_out;
    end else if (fire) begin
      s2_val_d = 1'b0;
    end

    if (fire && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_val_q  <= 1'b0;
      s1_in0_q  <= '0;
      s1_in1_q  <= '0;
      s1_in2_q  <= '0;
      s1_in3_q  <= '0;
      s1_mode_q <= '0;
      s2_val_q  <= 1'b0;
      out_q     <= '0;
      cnt_q     <= '0;
    end else begin
      s1_val_q  <= s1_val_d;
      s1_in0_q  <= s1_in0_d;
      s1_in1_q  <= s1_in1_d;
      s1_in2_q  <= s1_in2_d;
      s1_in3_q  <= s1_in3_d;
      s1_mode_q <= s1_mode_d;
      s2_val_q  <= s2_val_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out       = out_q;
  assign out_val   = s2_val_q;
  assign out_count = cnt_q;

`ifdef COMB_GATES_OAI_PIPE_POPCOUNT_EN
  localparam int unsigned ONES_W = $clog2(NBITS + 1);

  logic [ONES_W-1:0] ones_q, ones_d;
  logic [ONES_W-1:0] lane_ones;

  always_comb begin
    lane_ones = '0;
    for (int unsigned i = 0; i < NBITS; i++) begin
      lane_ones = lane_ones + ONES_W'(lane_out[i]);
    end
    ones_d = ones_q;
    if (advance) begin
      ones_d = lane_ones;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign out_ones = ones_q;
`endif

endmodule
